// File: rtl/processador_pio_pkg.sv
// Shared constants for the button input PIO: register map, edge selection
// and the debounce counter sizing helper.
package processador_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Counter must hold 0..n; a bypassed debouncer still gets a 1-bit width.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/processador_buttons_pio_if.sv
// Avalon-MM slave bus bundle for the button PIO (zero-wait-state reads).
interface processador_buttons_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/processador_debounce_bit.sv
// One input pin: two-flop synchroniser followed by a stable-count debouncer.
module processador_debounce_bit
    import processador_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE            = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic stable
);

    logic sync1, sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stable <= IDLE;
                else          stable <= sync2;
            end
        end else begin : g_debounce
            localparam int CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;

            // A bounce back to the accepted level restarts the count from zero.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable <= IDLE;
                    cnt    <= '0;
                end else if (sync2 == stable) begin
                    cnt    <= '0;
                end else if (cnt == LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt    <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/processador_buttons_pio.sv
// Button/switch input PIO: debounced levels, sticky edge capture (W1C) and a
// maskable level interrupt, behind an Avalon-MM slave port.
module processador_buttons_pio
    import processador_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = EDGE_FALLING,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    processador_buttons_pio_if.slave   bus,
    input  logic [WIDTH-1:0]           in_port,
    output logic                       irq
);

    logic [WIDTH-1:0] stable, stable_d, edge_hit, edge_capture, irq_mask, w1c;
    logic [31:0]      rdata;
    logic             wr;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        processador_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE            (IDLE_LEVEL[i])
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .stable  (stable[i])
        );
    end

    assign edge_hit = (EDGE_TYPE == EDGE_RISING) ? (stable & ~stable_d) :
                      (EDGE_TYPE == EDGE_ANY)    ? (stable ^ stable_d)  :
                                                   (~stable & stable_d);

    assign wr           = bus.chipselect & ~bus.write_n;
    assign w1c          = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^bus.writedata;

    // A new edge landing in the same cycle as its W1C clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d     <= IDLE_LEVEL;
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            stable_d     <= stable;
            edge_capture <= (edge_capture & ~w1c) | edge_hit;
            if (wr && bus.address == ADDR_IRQMASK)
                irq_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:    rdata[WIDTH-1:0] = stable;
            ADDR_IRQMASK: rdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rdata[WIDTH-1:0] = edge_capture;
            default:      ;
        endcase
    end

    assign bus.readdata = rdata;
    assign irq          = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_processador_buttons_pio.sv
// Bench for the button PIO: instance A (N=4, falling) and instance B (N=0, any edge).
module tb_processador_buttons_pio;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic [3:0] in_a, in_b;
    logic       irq_a, irq_b;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [31:0] sb_q[$];

    processador_buttons_pio_if bus_a();
    processador_buttons_pio_if bus_b();

    processador_buttons_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF)) dut_a (
        .clk(clk), .reset_n(reset_a), .bus(bus_a), .in_port(in_a), .irq(irq_a));

    processador_buttons_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IDLE_LEVEL(4'hF)) dut_b (
        .clk(clk), .reset_n(reset_b), .bus(bus_b), .in_port(in_b), .irq(irq_b));

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;
    vec_t vt[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic wr(input bit b, input logic [1:0] a, input logic [31:0] d);
        if (b) begin
            bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        end else begin
            bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        end
        tick();
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    endtask

    task automatic rd_chk(input bit b, input logic [1:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] got;
        sb_q.push_back(exp);
        if (b) bus_b.address = a; else bus_a.address = a;
        #1;
        got = b ? bus_b.readdata : bus_a.readdata;
        chk(nm, got, sb_q.pop_front());
    endtask

    initial begin
        vt[0] = '{1'b0, 2'd0, 32'h0,        32'hF, 1'b0};
        vt[1] = '{1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
        vt[2] = '{1'b0, 2'd2, 32'h0,        32'h0, 1'b0};
        vt[3] = '{1'b0, 2'd3, 32'h0,        32'h0, 1'b0};
        vt[4] = '{1'b1, 2'd0, 32'h0,        32'hF, 1'b0};
        vt[5] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b0};
        vt[6] = '{1'b1, 2'd2, 32'hFFFFFFF6, 32'h6, 1'b0};
        vt[7] = '{1'b1, 2'd3, 32'hF,        32'h0, 1'b0};
        vt[8] = '{1'b1, 2'd2, 32'h1,        32'h1, 1'b0};

        reset_a = 1'b0; reset_b = 1'b0;
        in_a = 4'hF; in_b = 4'hF;
        bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
        bus_b.address = 2'd0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
        repeat (3) tick();
        reset_a = 1'b1; reset_b = 1'b1;

        rd_chk(1'b0, 2'd0, 32'hF, "a_reset_data");
        chk("a_reset_irq", 32'(irq_a), 32'h0);
        rd_chk(1'b1, 2'd0, 32'hF, "b_reset_data");
        rd_chk(1'b1, 2'd3, 32'h0, "b_reset_cap");
        chk("b_reset_irq", 32'(irq_b), 32'h0);

        for (int i = 0; i < 10; i++) begin
            tick();
            rd_chk(1'b0, 2'd3, 32'h0, $sformatf("a_quiet_cap%0d", i));
            chk($sformatf("a_quiet_irq%0d", i), 32'(irq_a), 32'h0);
        end

        // Register map; the last entry leaves irq_mask = 1 for what follows.
        for (int i = 0; i < 9; i++) begin
            if (vt[i].wr) wr(1'b0, vt[i].addr, vt[i].wdata);
            rd_chk(1'b0, vt[i].addr, vt[i].exp, $sformatf("vec%0d_rd", i));
            chk($sformatf("vec%0d_irq", i), 32'(irq_a), 32'(vt[i].exp_irq));
        end

        // Press bit 0 just after edge 0: stable at edge 6, capture/irq at edge 7.
        in_a = 4'hE;
        repeat (5) tick();
        rd_chk(1'b0, 2'd0, 32'hF, "lat_data_e5");
        tick();
        rd_chk(1'b0, 2'd0, 32'hE, "lat_data_e6");
        rd_chk(1'b0, 2'd3, 32'h0, "lat_cap_e6");
        chk("lat_irq_e6", 32'(irq_a), 32'h0);
        tick();
        rd_chk(1'b0, 2'd3, 32'h1, "lat_cap_e7");
        chk("lat_irq_e7", 32'(irq_a), 32'h1);

        // 3-cycle glitch on bit 1 is rejected.
        in_a = 4'hC;
        repeat (3) tick();
        in_a = 4'hE;
        repeat (2) tick();
        rd_chk(1'b0, 2'd0, 32'hE, "glitch_mid");
        repeat (6) tick();
        rd_chk(1'b0, 2'd0, 32'hE, "glitch_data");
        rd_chk(1'b0, 2'd3, 32'h1, "glitch_cap");

        // 4-cycle pulse on bit 1 is accepted, then the release is accepted too.
        in_a = 4'hC;
        repeat (4) tick();
        in_a = 4'hE;
        repeat (2) tick();
        rd_chk(1'b0, 2'd0, 32'hC, "pulse_mid");
        repeat (8) tick();
        rd_chk(1'b0, 2'd0, 32'hE, "pulse_data");
        rd_chk(1'b0, 2'd3, 32'h3, "pulse_cap");
        chk("pulse_irq", 32'(irq_a), 32'h1);

        wr(1'b0, 2'd3, 32'h1);
        rd_chk(1'b0, 2'd3, 32'h2, "w1c_bit0");

        in_a = 4'hF;
        repeat (10) tick();
        rd_chk(1'b0, 2'd0, 32'hF, "release_data");
        rd_chk(1'b0, 2'd3, 32'h2, "rise_ignored");

        // New falling edge on bit 0 collides with a W1C of bit 0 at edge 7.
        in_a = 4'hE;
        repeat (6) tick();
        wr(1'b0, 2'd3, 32'h1);
        rd_chk(1'b0, 2'd3, 32'h3, "set_wins");

        wr(1'b0, 2'd3, 32'h2);
        rd_chk(1'b0, 2'd3, 32'h1, "w1c_bit1");
        chk("irq_pending", 32'(irq_a), 32'h1);
        wr(1'b0, 2'd2, 32'h0);
        chk("irq_masked", 32'(irq_a), 32'h0);
        rd_chk(1'b0, 2'd3, 32'h1, "mask_keeps_cap");
        rd_chk(1'b0, 2'd1, 32'h0, "dir_reads_zero");

        // Instance B: bypassed debounce, any edge; pin seen at edge 1, capture at edge 4.
        wr(1'b1, 2'd2, 32'h4);
        in_b = 4'hB;
        repeat (3) tick();
        rd_chk(1'b1, 2'd3, 32'h0, "b_press_cap_e3");
        rd_chk(1'b1, 2'd0, 32'hB, "b_press_data_e3");
        tick();
        rd_chk(1'b1, 2'd3, 32'h4, "b_press_cap_e4");
        chk("b_press_irq", 32'(irq_b), 32'h1);
        wr(1'b1, 2'd3, 32'h4);
        rd_chk(1'b1, 2'd3, 32'h0, "b_clear");

        in_b = 4'hF;
        repeat (3) tick();
        rd_chk(1'b1, 2'd3, 32'h0, "b_rel_cap_e3");
        tick();
        rd_chk(1'b1, 2'd3, 32'h4, "b_rel_cap_e4");
        wr(1'b1, 2'd3, 32'h4);

        in_b = 4'hB;
        repeat (4) tick();
        rd_chk(1'b1, 2'd3, 32'h4, "b_pre_reset_cap");
        reset_b = 1'b0;
        #1;
        rd_chk(1'b1, 2'd0, 32'hF, "b_async_data");
        rd_chk(1'b1, 2'd3, 32'h0, "b_async_cap");
        rd_chk(1'b1, 2'd2, 32'h0, "b_async_mask");
        chk("b_async_irq", 32'(irq_b), 32'h0);
        in_b = 4'hF;
        tick();
        reset_b = 1'b1;
        repeat (6) tick();
        rd_chk(1'b1, 2'd3, 32'h0, "b_no_edge_exit");
        rd_chk(1'b1, 2'd0, 32'hF, "b_exit_data");
        chk("b_exit_irq", 32'(irq_b), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
